serial_shift_ctrl: RTL

Controller that sequences a WIDTH-bit edge-triggered shift register, built from D flip-flop storage, to serialise parallel words.
- Accepts a word through a valid/ready load handshake.
- Shifts the word out one bit per cycle, stalling on hold, then pulses done.
- Sits between a parallel producer and any serial consumer in the design.

---
 rtl/serial_shift_ctrl_pkg.sv | 13 +
 rtl/serial_shift_ctrl_bit_cnt.sv | 28 ++
 rtl/serial_shift_ctrl.sv | 77 +++++++
 3 files changed

// File: rtl/serial_shift_ctrl_pkg.sv
// Shared encodings and default sizing for the serial shift controller.
package serial_shift_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 3;

endpackage

// File: rtl/serial_shift_ctrl_bit_cnt.sv
// Bit counter for the shift controller: sync zero wins over inc, flags the last bit position.
module shift_bit_cnt
    import serial_shift_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic clk,
    input  logic clear,
    input  logic inc,
    input  logic zero,
    output logic at_last
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge clear) begin
        if (clear)
            cnt <= '0;
        else if (zero)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + 1'b1;
    end

    assign at_last = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/serial_shift_ctrl.sv
// Serialises WIDTH-bit words accepted on a valid/ready handshake, one bit per
// unheld cycle, followed by a single-cycle done pulse.
module serial_shift_ctrl
    import serial_shift_ctrl_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CNT_W     = DEF_CNT_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             hold,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic             step;
    logic             load;
    logic             at_last;

    assign step = (state == ST_SHIFT) & ~hold;
    assign load = (state == ST_IDLE) & in_valid;

    shift_bit_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .clear   (clear),
        .inc     (step),
        .zero    (load | (step & at_last)),
        .at_last (at_last)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= ST_IDLE;
            shreg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        shreg <= in_data;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!hold) begin
                        // Shift toward the output end, zero-filling behind.
                        if (MSB_FIRST)
                            shreg <= {shreg[WIDTH-2:0], 1'b0};
                        else
                            shreg <= {1'b0, shreg[WIDTH-1:1]};
                        if (at_last)
                            state <= ST_DONE;
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready   = (state == ST_IDLE) & ~clear;
    assign sout       = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign sout_valid = (state == ST_SHIFT) & ~hold;
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);

endmodule
